// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM status encoding and the cache arbiter FSM states.
// Grant identifiers are used by the cache_arbiter ARB_FAIR_EN build.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_ICACHE = 1'b0,
        GNT_DCACHE = 1'b1
    } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates icache and dcache requests onto one RAM port; dcache may hold the grant for DBURST words.
// Build option: define ARB_FAIR_EN for alternating tie-break; default build gives dcache fixed priority.
module cache_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DBURST = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam logic [2:0] BURST_LEN = 3'(DBURST);

    arb_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       dreq_s;
    logic       i_done_s;
    logic       d_done_s;
    logic       d_wins_tie_s;
    logic       grant_i_s;
    logic       grant_d_s;

    assign dreq_s   = dREN | dWEN;
    // A transfer completes only if the owner is still requesting when RAM reports ACCESS.
    assign i_done_s = (state_q == IGNT) && iREN   && (ramstate == ACCESS);
    assign d_done_s = (state_q == DGNT) && dreq_s && (ramstate == ACCESS);

`ifdef ARB_FAIR_EN
    grant_t last_q, last_d;

    assign d_wins_tie_s = (last_q == GNT_ICACHE);

    // Remember which cache was granted most recently.
    always_comb begin
        last_d = last_q;
        if (grant_d_s) begin
            last_d = GNT_DCACHE;
        end else if (grant_i_s) begin
            last_d = GNT_ICACHE;
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant flag register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_q <= GNT_ICACHE;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign d_wins_tie_s = 1'b1;
`endif

    assign grant_d_s = (state_q == IDLE) && dreq_s && (!iREN || d_wins_tie_s);
    assign grant_i_s = (state_q == IDLE) && iREN && !grant_d_s;

    // Next-state and burst counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_d_s) begin
                    state_d = DGNT;
                    cnt_d   = 3'd0;
                end else if (grant_i_s) begin
                    state_d = IGNT;
                end else begin
                    state_d = IDLE;
                end
            end
            IGNT: begin
                if (!iREN || i_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = IGNT;
                end
            end
            DGNT: begin
                if (!dreq_s) begin
                    state_d = IDLE;
                end else if (d_done_s) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_d == BURST_LEN) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DGNT;
                    end
                end else begin
                    state_d = DGNT;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and burst counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RAM strobes follow the registered grant; wait/load react to RAM status in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = 32'd0;
        dload    = 32'd0;
        case (state_q)
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (i_done_s) begin
                    iwait = 1'b0;
                    iload = ramload;
                end else begin
                    iwait = 1'b1;
                end
            end
            DGNT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (d_done_s) begin
                    dwait = 1'b0;
                    dload = ramload;
                end else begin
                    dwait = 1'b1;
                end
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model. Honours ARB_FAIR_EN when the bundle is built with it.
module tb_cache_arbiter;
    import cpu_types_pkg::*;

    localparam int DBURST = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    cache_arbiter #(.DBURST(DBURST)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    task automatic clear_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
        ramload = 32'd0; ramstate = FREE;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        next_cycle();
        next_cycle();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        #12;
        checks++;
        if ({iwait, dwait} !== 2'b11) begin
            failures++; $display("FAIL reset_waits got=%b exp=11", {iwait, dwait});
        end
        checks++;
        if ({ramREN, ramWEN, ramaddr, ramstore, iload, dload} !== 130'd0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {ramREN, ramWEN, ramaddr, ramstore, iload, dload});
        end
        iREN = 1'b1; dWEN = 1'b1; daddr = 32'h10; ramstate = ACCESS; ramload = 32'h1234;
        next_cycle();
        next_cycle();
        @(negedge CLK);
        checks++;
        if ({ramREN, ramWEN, iwait, dwait, iload, dload} !== {2'b00, 2'b11, 64'd0}) begin
            failures++; $display("FAIL reset_held got=%h exp=%h", {ramREN, ramWEN, iwait, dwait, iload, dload}, {2'b00, 2'b11, 64'd0});
        end
        clear_inputs();
        next_cycle();
        nRST = 1'b1;
        next_cycle();
    endtask

    task automatic test_icache_read();
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'hDEADBEEF;
        @(negedge CLK);
        checks++;
        if ({ramREN, iwait} !== 2'b01) begin
            failures++; $display("FAIL iread_idle got=%b exp=01", {ramREN, iwait});
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if ({ramREN, ramaddr, iwait, iload} !== {1'b1, 32'h40, 1'b1, 32'd0}) begin
            failures++; $display("FAIL iread_busy got=%h exp=%h", {ramREN, ramaddr, iwait, iload}, {1'b1, 32'h40, 1'b1, 32'd0});
        end
        next_cycle();
        ramstate = ACCESS;
        @(negedge CLK);
        checks++;
        if ({iwait, iload, dwait} !== {1'b0, 32'hDEADBEEF, 1'b1}) begin
            failures++; $display("FAIL iread_done got=%h exp=%h", {iwait, iload, dwait}, {1'b0, 32'hDEADBEEF, 1'b1});
        end
        next_cycle();
        iREN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        checks++;
        if ({ramREN, iwait, iload} !== {1'b0, 1'b1, 32'd0}) begin
            failures++; $display("FAIL iread_after got=%h exp=%h", {ramREN, iwait, iload}, {1'b0, 1'b1, 32'd0});
        end
        next_cycle();
    endtask

    task automatic test_dcache_write();
        dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h5; ramstate = ACCESS;
        @(negedge CLK);
        checks++;
        if ({ramWEN, dwait} !== 2'b01) begin
            failures++; $display("FAIL dwrite_idle got=%b exp=01", {ramWEN, dwait});
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if ({ramREN, ramWEN, ramaddr, ramstore, dwait} !== {2'b01, 32'h3100, 32'h5, 1'b0}) begin
            failures++; $display("FAIL dwrite_done got=%h exp=%h", {ramREN, ramWEN, ramaddr, ramstore, dwait}, {2'b01, 32'h3100, 32'h5, 1'b0});
        end
        next_cycle();
        dWEN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        checks++;
        if ({ramWEN, dwait} !== 2'b01) begin
            failures++; $display("FAIL dwrite_after got=%b exp=01", {ramWEN, dwait});
        end
        next_cycle();
    endtask

    task automatic test_burst();
        iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h80; ramstate = ACCESS; ramload = 32'hA0;
        @(negedge CLK);
        checks++;
        if ({iwait, dwait, ramREN} !== 3'b110) begin
            failures++; $display("FAIL burst_idle got=%b exp=110", {iwait, dwait, ramREN});
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if ({dwait, iwait, ramaddr, dload} !== {2'b01, 32'h80, 32'hA0}) begin
            failures++; $display("FAIL burst_word0 got=%h exp=%h", {dwait, iwait, ramaddr, dload}, {2'b01, 32'h80, 32'hA0});
        end
        next_cycle();
        daddr = 32'h84; ramload = 32'hA4;
        @(negedge CLK);
        checks++;
        if ({dwait, iwait, ramaddr, dload} !== {2'b01, 32'h84, 32'hA4}) begin
            failures++; $display("FAIL burst_word1 got=%h exp=%h", {dwait, iwait, ramaddr, dload}, {2'b01, 32'h84, 32'hA4});
        end
        next_cycle();
        dREN = 1'b0; ramload = 32'h1C;
        @(negedge CLK);
        checks++;
        if ({iwait, dwait, ramREN} !== 3'b110) begin
            failures++; $display("FAIL burst_gap got=%b exp=110", {iwait, dwait, ramREN});
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if ({iwait, ramaddr, iload} !== {1'b0, 32'h200, 32'h1C}) begin
            failures++; $display("FAIL burst_icache got=%h exp=%h", {iwait, ramaddr, iload}, {1'b0, 32'h200, 32'h1C});
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_tie();
        int g[$];
        int exp_g;
        logic prev_active;
        logic active;
        do_reset();
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h1000; daddr = 32'h2000; ramstate = ACCESS;
        prev_active = 1'b0;
        for (int cyc = 0; cyc < 60 && g.size() < 4; cyc++) begin
            @(negedge CLK);
            active = ramREN | ramWEN;
            if (active && !prev_active) begin
                g.push_back(dwait == 1'b0 ? 2 : (iwait == 1'b0 ? 1 : 0));
            end
            prev_active = active;
            next_cycle();
        end
        checks++;
        if (g.size() != 4) begin
            failures++; $display("FAIL tie_grant_count got=%0d exp=4", g.size());
        end
        for (int k = 0; k < g.size(); k++) begin
`ifdef ARB_FAIR_EN
            exp_g = (k % 2 == 0) ? 2 : 1;
`else
            exp_g = 2;
`endif
            checks++;
            if (g[k] != exp_g) begin
                failures++; $display("FAIL tie_grant%0d got=%0d exp=%0d (1=I 2=D)", k, g[k], exp_g);
            end
        end
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_drop_and_error();
        iREN = 1'b1; iaddr = 32'h44; ramstate = BUSY; ramload = 32'h77;
        next_cycle();
        iREN = 1'b0; ramstate = ACCESS;
        @(negedge CLK);
        checks++;
        if ({iwait, iload} !== {1'b1, 32'd0}) begin
            failures++; $display("FAIL idrop_no_pulse got=%h exp=%h", {iwait, iload}, {1'b1, 32'd0});
        end
        next_cycle();
        dREN = 1'b1; daddr = 32'h500; ramstate = ERROR;
        next_cycle();
        for (int n = 0; n < 3; n++) begin
            @(negedge CLK);
            checks++;
            if ({ramREN, dwait, dload} !== {2'b11, 32'd0}) begin
                failures++; $display("FAIL derror_hold%0d got=%h exp=%h", n, {ramREN, dwait, dload}, {2'b11, 32'd0});
            end
            next_cycle();
        end
        ramstate = ACCESS;
        @(negedge CLK);
        checks++;
        if ({ramREN, dwait, dload} !== {1'b1, 1'b0, 32'h77}) begin
            failures++; $display("FAIL derror_then_access got=%h exp=%h", {ramREN, dwait, dload}, {1'b1, 1'b0, 32'h77});
        end
        next_cycle();
        dREN = 1'b0; ramstate = BUSY;
        @(negedge CLK);
        checks++;
        if ({ramREN, dwait} !== 2'b01) begin
            failures++; $display("FAIL ddrop_no_pulse got=%b exp=01", {ramREN, dwait});
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0) begin
            failures++; $display("FAIL ddrop_idle got=%b exp=0", ramREN);
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        dWEN = 1'b1; daddr = 32'h900; dstore = 32'h3; ramstate = BUSY;
        next_cycle();
        @(negedge CLK);
        checks++;
        if ({ramWEN, dwait} !== 2'b11) begin
            failures++; $display("FAIL rmid_granted got=%b exp=11", {ramWEN, dwait});
        end
        nRST = 1'b0;
        ramstate = ACCESS;
        #1;
        checks++;
        if ({ramWEN, dwait, ramaddr} !== {2'b01, 32'd0}) begin
            failures++; $display("FAIL rmid_abandon got=%h exp=%h", {ramWEN, dwait, ramaddr}, {2'b01, 32'd0});
        end
        next_cycle();
        nRST = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge CLK);
            checks++;
            if ({ramWEN, dwait} !== ((n == 1 || n == 2) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL rmid_burst%0d got=%b exp=%b", n, {ramWEN, dwait}, ((n == 1 || n == 2) ? 2'b10 : 2'b01));
            end
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        int owner;
        int words;
        logic last_was_i;
        logic pick_d;
        logic dreq;
        logic idone;
        logic ddone;
        int r;
        logic [131:0] exp_v;
        logic [131:0] got_v;
        logic e_rren, e_rwen, e_iw, e_dw;
        logic [31:0] e_raddr, e_rstore, e_il, e_dl;
        do_reset();
        owner = 0; words = 0; last_was_i = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            iREN     = ($urandom_range(0, 9) < 6);
            r        = $urandom_range(0, 9);
            dREN     = (r < 3);
            dWEN     = (r >= 3 && r < 6);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            @(negedge CLK);
            dreq  = dREN | dWEN;
            idone = (owner == 1) && iREN && (ramstate == ACCESS);
            ddone = (owner == 2) && dreq && (ramstate == ACCESS);
            e_rren = 1'b0; e_rwen = 1'b0; e_raddr = 32'd0; e_rstore = 32'd0;
            e_iw = 1'b1; e_dw = 1'b1; e_il = 32'd0; e_dl = 32'd0;
            if (owner == 1) begin
                e_rren = 1'b1; e_raddr = iaddr;
                if (idone) begin e_iw = 1'b0; e_il = ramload; end
            end else if (owner == 2) begin
                e_rren = dREN; e_rwen = dWEN; e_raddr = daddr; e_rstore = dstore;
                if (ddone) begin e_dw = 1'b0; e_dl = ramload; end
            end
            exp_v = {e_rren, e_rwen, e_raddr, e_rstore, e_iw, e_dw, e_il, e_dl};
            got_v = {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload};
            checks++;
            if (got_v !== exp_v) begin
                failures++; $display("FAIL random_cycle%0d got=%h exp=%h", n, got_v, exp_v);
            end
            if (owner == 0) begin
`ifdef ARB_FAIR_EN
                pick_d = last_was_i;
`else
                pick_d = 1'b1;
`endif
                if (dreq && (!iREN || pick_d)) begin
                    owner = 2; words = 0; last_was_i = 1'b0;
                end else if (iREN) begin
                    owner = 1; last_was_i = 1'b1;
                end
            end else if (owner == 1) begin
                if (!iREN || idone) owner = 0;
            end else begin
                if (!dreq) begin
                    owner = 0;
                end else if (ddone) begin
                    words++;
                    if (words == DBURST) owner = 0;
                end
            end
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_burst();
        test_tie();
        test_drop_and_error();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
